// File: rtl/shift_counter_pkg.sv
// -----------------------------------------------------------------------------
// shift_counter_pkg
//   Shared constants for the parametrised Johnson / ring counter family.
//   - mode_e : counter flavour (Johnson = 2*W states, ring = W states)
//   - dir_e  : shift direction (forward = toward MSB, reverse = toward LSB)
//   - phase_width() : width of a phase index able to hold 0 .. 2*W-1
// -----------------------------------------------------------------------------
package shift_counter_pkg;

   typedef enum logic {
      MODE_JOHNSON = 1'b0,
      MODE_RING    = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_REV = 1'b1
   } dir_e;

   // Johnson mode has the larger state space (2*W), so it sizes the index.
   function automatic int phase_width(input int w);
      return $clog2(2 * w);
   endfunction

endpackage

// File: rtl/shift_counter_phase.sv
// -----------------------------------------------------------------------------
// shift_counter_phase
//   Purely combinational decoder: classifies a counter value as legal or not
//   for the given mode and returns its phase index.
// Ports
//   value  in   WIDTH    counter value to classify
//   mode   in   1        0 = Johnson, 1 = ring
//   phase  out  PHASE_W  phase index (0 for an illegal value)
//   legal  out  1        value is a reachable state of the selected mode
// -----------------------------------------------------------------------------
module shift_counter_phase
   import shift_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PHASE_W = phase_width(WIDTH)
) (
   input  logic [WIDTH-1:0]   value,
   input  logic               mode,
   output logic [PHASE_W-1:0] phase,
   output logic               legal
);

   // One extra bit so 2*WIDTH itself is representable before subtracting.
   localparam int CNT_W = PHASE_W + 1;

   logic [WIDTH-1:0]   inv;
   logic               therm_lo;
   logic               therm_hi;
   logic               one_hot;
   logic [CNT_W-1:0]   ones;
   logic [PHASE_W-1:0] bit_idx;

   always_comb begin
      inv      = ~value;
      // x is a low-ones thermometer (0..0111) exactly when x & (x+1) == 0.
      therm_lo = ((value & (value + WIDTH'(1))) == '0);
      // High-ones states (1..10, .., 10..0) are bitwise complements of those.
      therm_hi = ((inv & (inv + WIDTH'(1))) == '0);
      one_hot  = (value != '0) && ((value & (value - WIDTH'(1))) == '0);

      ones    = '0;
      bit_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + CNT_W'(value[i]);
         if (value[i]) begin
            bit_idx = PHASE_W'(i);
         end
      end

      phase = '0;
      legal = 1'b0;
      if (mode == MODE_RING) begin
         legal = one_hot;
         if (one_hot) begin
            phase = bit_idx;
         end
      end else begin
         legal = therm_lo | therm_hi;
         if (legal) begin
            // Filling half: bit0 set, phase = number of ones.
            // Draining half: bit0 clear, phase counts down from 2W.
            if (value[0]) begin
               phase = PHASE_W'(ones);
            end else if (ones != '0) begin
               phase = PHASE_W'(CNT_W'(2 * WIDTH) - ones);
            end
         end
      end
   end

endmodule

// File: rtl/shift_counter_gen.sv
// -----------------------------------------------------------------------------
// shift_counter_gen
//   Parametrised twisted-ring (Johnson) / ring counter used as a multi-phase
//   sequencer. Runtime mode and direction, enable, checked parallel load and
//   self-correction of illegal states; decoded phase and wrap/err pulses.
// Ports
//   clk       in   1        clock, rising edge
//   rst       in   1        asynchronous active-low reset; release is expected
//                           to be synchronised to clk upstream
//   en        in   1        advance one step per cycle
//   dir       in   1        0 = toward MSB, 1 = toward LSB
//   mode      in   1        0 = Johnson (2*WIDTH states), 1 = ring (WIDTH)
//   load      in   1        parallel load request
//   load_val  in   WIDTH    value to load (rejected if illegal for mode)
//   count     out  WIDTH    counter state
//   phase     out  PHASE_W  phase index of count (combinational)
//   wrap      out  1        one-cycle pulse after an en step across phase 0
//   err       out  1        one-cycle pulse after an illegal load/state fix
// -----------------------------------------------------------------------------
module shift_counter_gen
   import shift_counter_pkg::*;
#(
   parameter  int WIDTH   = 4,
   localparam int PHASE_W = phase_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic               mode,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   output logic [WIDTH-1:0]   count,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap,
   output logic               err
);

   localparam logic [PHASE_W-1:0] LAST_J = PHASE_W'(2 * WIDTH - 1);
   localparam logic [PHASE_W-1:0] LAST_R = PHASE_W'(WIDTH - 1);

   logic [WIDTH-1:0]   count_q, count_d;
   logic               mode_q, mode_d;
   logic               wrap_q, wrap_d;
   logic               err_q, err_d;

   logic [PHASE_W-1:0] cur_phase;
   logic               cur_legal;
   logic               load_legal;
   logic [PHASE_W-1:0] load_phase_unused;

   logic               is_johnson;
   logic               fb_fwd;
   logic               fb_rev;
   logic [WIDTH-1:0]   step_val;
   logic [PHASE_W-1:0] last_phase;

   function automatic logic [WIDTH-1:0] seed(input logic m);
      return (m == MODE_RING) ? WIDTH'(1) : '0;
   endfunction

   // Phase/legality of the live state, interpreted in the mode it was built in.
   shift_counter_phase #(.WIDTH(WIDTH), .PHASE_W(PHASE_W)) u_phase (
      .value (count_q),
      .mode  (mode_q),
      .phase (cur_phase),
      .legal (cur_legal)
   );

   // Legality of a load request against the requested mode.
   shift_counter_phase #(.WIDTH(WIDTH), .PHASE_W(PHASE_W)) u_load_chk (
      .value (load_val),
      .mode  (mode),
      .phase (load_phase_unused),
      .legal (load_legal)
   );

   always_comb begin
      count_d = count_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;

      // Johnson feeds back the inverted end bit, ring the plain end bit.
      is_johnson = (mode_q == MODE_JOHNSON);
      fb_fwd     = count_q[WIDTH-1] ^ is_johnson;
      fb_rev     = count_q[0] ^ is_johnson;
      step_val   = (dir == DIR_FWD) ? {count_q[WIDTH-2:0], fb_fwd}
                                    : {fb_rev, count_q[WIDTH-1:1]};
      last_phase = is_johnson ? LAST_J : LAST_R;

      if (mode != mode_q) begin
         // Mode switch reseeds silently; everything else is dropped.
         count_d = seed(mode);
         mode_d  = mode;
      end else if (load) begin
         if (load_legal) begin
            count_d = load_val;
         end else begin
            count_d = seed(mode);
            err_d   = 1'b1;
         end
      end else if (!cur_legal) begin
         // Self-correct instead of stepping a corrupted pattern.
         count_d = seed(mode);
         err_d   = 1'b1;
      end else if (en) begin
         count_d = step_val;
         wrap_d  = (dir == DIR_FWD) ? (cur_phase == last_phase)
                                    : (cur_phase == '0);
      end
   end

   // Reset value follows the mode pin so the counter comes out of reset
   // already seeded for the selected flavour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= seed(mode);
         mode_q  <= mode;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign count = count_q;
   assign phase = cur_phase;
   assign wrap  = wrap_q;
   assign err   = err_q;

endmodule
